dsp_mac_coproc: RTL and testbench

//  Sequential signed multiply / multiply-accumulate coprocessor sitting downstream of the pipelined core's ID stage.

---
 rtl/dsp_pkg.sv | 26 ++
 rtl/dsp_seq_mult.sv | 40 ++++
 rtl/dsp_mac_coproc.sv | 144 ++++++++++++++
 tb/tb_dsp_mac_coproc.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/dsp_pkg.sv
// Shared encodings and sizing for the DSP multiply / MAC coprocessor.
package dsp_pkg;

   localparam int DSP_WIDTH = 32;

   function automatic int dsp_cnt_w(input int width);
      return $clog2(width);
   endfunction

   localparam int DSP_CNT_W = dsp_cnt_w(DSP_WIDTH);

   typedef enum logic [1:0] {
      DSP_MUL    = 2'b00,
      DSP_MULH   = 2'b01,
      DSP_MAC    = 2'b10,
      DSP_CLRACC = 2'b11
   } dsp_op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_CALC = 2'b01,
      S_FIX  = 2'b10,
      S_DONE = 2'b11
   } dsp_state_e;

endpackage

// File: rtl/dsp_seq_mult.sv
// Unsigned radix-2 shift-add multiplier: one multiplier bit retired per step.
module dsp_seq_mult
   import dsp_pkg::*;
#(
   parameter int WIDTH = DSP_WIDTH
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 load,
   input  logic [WIDTH-1:0]     mcand,
   input  logic [WIDTH-1:0]     mplier,
   input  logic                 step,
   output logic [2*WIDTH-1:0]   product
);

   logic [2*WIDTH-1:0] mcand_q;
   logic [2*WIDTH-1:0] product_q;
   logic [WIDTH-1:0]   mplier_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mcand_q   <= '0;
         mplier_q  <= '0;
         product_q <= '0;
      end else if (load) begin
         mcand_q   <= {{WIDTH{1'b0}}, mcand};
         mplier_q  <= mplier;
         product_q <= '0;
      end else if (step) begin
         if (mplier_q[0]) begin
            product_q <= product_q + mcand_q;
         end
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
      end
   end

   assign product = product_q;

endmodule

// File: rtl/dsp_mac_coproc.sv
// Sequential signed MUL / MULH / MAC / CLRACC coprocessor with a one-cycle write-back pulse.
// Outputs are registered from the FSM state, so they trail the state register by one cycle.
module dsp_mac_coproc
   import dsp_pkg::*;
#(
   parameter int WIDTH      = DSP_WIDTH,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [1:0]            op,
   input  logic [WIDTH-1:0]      rs1_data,
   input  logic [WIDTH-1:0]      rs2_data,
   input  logic [REG_ADDR_W-1:0] rd,
   output logic                  busy,
   output logic                  done,
   output logic                  wb_we,
   output logic [REG_ADDR_W-1:0] wb_rd,
   output logic [WIDTH-1:0]      wb_data,
   output logic                  drop
);

   localparam int CNT_W = dsp_cnt_w(WIDTH);
   localparam int PW    = 2 * WIDTH;

   dsp_state_e            state_q;
   dsp_op_e               op_q;
   logic [REG_ADDR_W-1:0] rd_q;
   logic                  sign_q;
   logic [CNT_W-1:0]      cnt_q;
   logic [PW-1:0]         acc_q;
   logic [PW-1:0]         prod_q;
   logic                  busy_q;
   logic                  done_q;
   logic                  wb_we_q;
   logic                  drop_q;
   logic [REG_ADDR_W-1:0] wb_rd_q;
   logic [WIDTH-1:0]      wb_data_q;

   logic                  accept;
   logic                  mult_load;
   logic [WIDTH-1:0]      mag_a;
   logic [WIDTH-1:0]      mag_b;
   logic [PW-1:0]         mag_prod;
   logic [PW-1:0]         prod_d;
   logic [PW-1:0]         acc_d;
   logic [WIDTH-1:0]      wb_data_d;

   // busy_q still high in the done-output cycle, so a start there is dropped.
   assign accept    = start && (state_q == S_IDLE) && !busy_q;
   assign mult_load = accept && (op != DSP_CLRACC);
   assign mag_a     = rs1_data[WIDTH-1] ? -rs1_data : rs1_data;
   assign mag_b     = rs2_data[WIDTH-1] ? -rs2_data : rs2_data;
   assign prod_d    = sign_q ? -mag_prod : mag_prod;
   assign acc_d     = acc_q + prod_d;

   dsp_seq_mult #(.WIDTH(WIDTH)) u_mult (
      .clk     (clk),
      .reset   (reset),
      .load    (mult_load),
      .mcand   (mag_a),
      .mplier  (mag_b),
      .step    (state_q == S_CALC),
      .product (mag_prod)
   );

   always_comb begin
      wb_data_d = '0;
      case (op_q)
         DSP_MUL:  wb_data_d = prod_q[WIDTH-1:0];
         DSP_MULH: wb_data_d = prod_q[PW-1:WIDTH];
         DSP_MAC:  wb_data_d = acc_q[WIDTH-1:0];
         default:  wb_data_d = '0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         op_q      <= DSP_MUL;
         rd_q      <= '0;
         sign_q    <= 1'b0;
         cnt_q     <= '0;
         acc_q     <= '0;
         prod_q    <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         wb_we_q   <= 1'b0;
         drop_q    <= 1'b0;
         wb_rd_q   <= '0;
         wb_data_q <= '0;
      end else begin
         done_q  <= 1'b0;
         wb_we_q <= 1'b0;
         drop_q  <= start && !accept;
         busy_q  <= (state_q != S_IDLE);
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  op_q    <= dsp_op_e'(op);
                  rd_q    <= rd;
                  sign_q  <= rs1_data[WIDTH-1] ^ rs2_data[WIDTH-1];
                  cnt_q   <= CNT_W'(WIDTH - 1);
                  state_q <= (op == DSP_CLRACC) ? S_DONE : S_CALC;
               end
            end
            S_CALC: begin
               if (cnt_q == '0) begin
                  state_q <= S_FIX;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            S_FIX: begin
               prod_q <= prod_d;
               if (op_q == DSP_MAC) begin
                  acc_q <= acc_d;
               end
               state_q <= S_DONE;
            end
            S_DONE: begin
               done_q    <= 1'b1;
               wb_we_q   <= (op_q != DSP_CLRACC) && (rd_q != '0);
               wb_rd_q   <= rd_q;
               wb_data_q <= wb_data_d;
               if (op_q == DSP_CLRACC) begin
                  acc_q <= '0;
               end
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign wb_we   = wb_we_q;
   assign wb_rd   = wb_rd_q;
   assign wb_data = wb_data_q;
   assign drop    = drop_q;

endmodule

// File: tb/tb_dsp_mac_coproc.sv
// Scoreboard bench for dsp_mac_coproc: directed ops push expected write-backs, a monitor checks them on done.
module tb_dsp_mac_coproc;

   localparam int W = 32;

   typedef struct {
      logic [4:0]   rd;
      logic [W-1:0] data;
      logic         we;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [1:0]   op;
   logic [W-1:0] rs1_data;
   logic [W-1:0] rs2_data;
   logic [4:0]   rd;
   logic         busy;
   logic         done;
   logic         wb_we;
   logic [4:0]   wb_rd;
   logic [W-1:0] wb_data;
   logic         drop;

   exp_t exp_q[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   dsp_mac_coproc #(.WIDTH(W), .REG_ADDR_W(5)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .op       (op),
      .rs1_data (rs1_data),
      .rs2_data (rs2_data),
      .rd       (rd),
      .busy     (busy),
      .done     (done),
      .wb_we    (wb_we),
      .wb_rd    (wb_rd),
      .wb_data  (wb_data),
      .drop     (drop)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (wb_we && !done) begin
            n_fail++;
            $display("FAIL we_without_done: wb_we=1 while done=0");
         end
         if (done) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL unexpected_done: got rd=%0d data=%h, expected no write-back", wb_rd, wb_data);
            end else begin
               e = exp_q.pop_front();
               chk("wb_rd", 64'(wb_rd), 64'(e.rd));
               chk("wb_data", 64'(wb_data), 64'(e.data));
               chk("wb_we", 64'(wb_we), 64'(e.we));
            end
         end
      end
   end

   task automatic drive(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [4:0] r);
      op = o; rs1_data = a; rs2_data = b; rd = r; start = 1'b1;
   endtask

   // Counts edges after the start-sampling edge until done is seen (#1 after each edge).
   task automatic wait_done(input int already, output int lat);
      lat = already;
      while (!done && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!done) begin
         n_cmp++;
         n_fail++;
         $display("FAIL done_timeout: no done within %0d edges, expected one", lat);
      end
   endtask

   task automatic run_op(input string name, input logic [1:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [4:0] r, input logic [W-1:0] exp_d,
                         input logic exp_we, input int exp_lat, input logic start_in_done);
      int lat;
      exp_t e;
      @(negedge clk);
      drive(o, a, b, r);
      e.rd = r; e.data = exp_d; e.we = exp_we;
      exp_q.push_back(e);
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(0, lat);
      chk({name, "_latency"}, 64'(lat), 64'(exp_lat));
      chk({name, "_busy_in_done"}, 64'(busy), 64'd1);
      if (start_in_done) begin
         drive(2'b00, 32'd4, 32'd4, 5'd2);
         @(posedge clk); #1;
         start = 1'b0;
         chk({name, "_drop_in_done"}, 64'(drop), 64'd1);
      end else begin
         @(posedge clk); #1;
      end
      chk({name, "_busy_after"}, 64'(busy), 64'd0);
      chk({name, "_done_after"}, 64'(done), 64'd0);
   endtask

   initial begin : stim
      int lat;
      exp_t e;
      reset = 1'b1; start = 1'b0; op = '0; rs1_data = '0; rs2_data = '0; rd = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_wb_we", 64'(wb_we), 64'd0);
      chk("rst_drop", 64'(drop), 64'd0);
      chk("rst_wb_rd", 64'(wb_rd), 64'd0);
      chk("rst_wb_data", 64'(wb_data), 64'd0);
      @(negedge clk);
      reset = 1'b0;

      run_op("mul_7_m3", 2'b00, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 1'b1, 34, 1'b0);
      run_op("mulh_min_min", 2'b01, 32'h8000_0000, 32'h8000_0000, 5'd6, 32'h4000_0000, 1'b1, 34, 1'b0);
      run_op("mulh_m1_1", 2'b01, 32'hFFFF_FFFF, 32'd1, 5'd7, 32'hFFFF_FFFF, 1'b1, 34, 1'b0);
      run_op("clracc", 2'b11, 32'd0, 32'd0, 5'd8, 32'd0, 1'b0, 1, 1'b0);
      run_op("mac_3_4", 2'b10, 32'd3, 32'd4, 5'd9, 32'd12, 1'b1, 34, 1'b0);
      run_op("mac_m10_2", 2'b10, 32'hFFFF_FFF6, 32'd2, 5'd10, 32'hFFFF_FFF8, 1'b1, 34, 1'b0);

      // Second start while computing: dropped once, in-flight MUL unaffected.
      @(negedge clk);
      drive(2'b00, 32'd5, 32'd6, 5'd11);
      e.rd = 5'd11; e.data = 32'd30; e.we = 1'b1;
      exp_q.push_back(e);
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      drive(2'b00, 32'd100, 32'd100, 5'd12);
      @(posedge clk); #1;
      start = 1'b0;
      chk("busy_drop_1st", 64'(drop), 64'd1);
      chk("busy_during_calc", 64'(busy), 64'd1);
      @(posedge clk); #1;
      chk("busy_drop_2nd", 64'(drop), 64'd0);
      wait_done(11, lat);
      chk("busy_drop_latency", 64'(lat), 64'd34);
      repeat (40) @(posedge clk);

      // Reset mid-MAC aborts it and clears the accumulator.
      @(negedge clk);
      drive(2'b10, 32'd2, 32'd2, 5'd13);
      @(posedge clk); #1;
      start = 1'b0;
      repeat (14) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("abort_busy", 64'(busy), 64'd0);
      repeat (40) @(posedge clk);
      run_op("mac_1_1_after_rst", 2'b10, 32'd1, 32'd1, 5'd14, 32'd1, 1'b1, 34, 1'b0);

      run_op("mul_rd0", 2'b00, 32'd9, 32'd9, 5'd0, 32'd81, 1'b0, 34, 1'b0);
      run_op("mul_start_in_done", 2'b00, 32'd2, 32'd3, 5'd1, 32'd6, 1'b1, 34, 1'b1);
      repeat (40) @(posedge clk);

      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
